rvv_backend_rob_result_collector: RTL and testbench
===================================================

# rvv_backend_rob_result_collector

Receiving end of the PU-to-ROB result handshake. Each processing unit (ALU, MUL, DIV, PMTRDT, LSU, …) presents a `PU2ROB_t` result with valid/ready. This block buffers those results in small per-PU FIFOs, round-robin arbitrates among them, and drives up to `NUM_WR` ROB write ports per cycle. It owns the `result_ready` seen by every PU and is flushed by `trap_flush_rvv`.

## Interface

Parameters:
- `NUM_PU`, default 4: number of PU result inputs.
- `NUM_WR`, default 2: ROB write ports per cycle, 1 ≤ `NUM_WR` ≤ `NUM_PU`.
- `FIFO_DEPTH`, default 2: entries per PU FIFO, a power of two ≥ 2.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. Asynchronous, active-high: the block is in reset while this signal is 1, despite the `_n` suffix.
- `trap_flush_rvv`, input, 1: synchronous flush.
- `pu_result_valid`, input, `[NUM_PU]`: PU result valid.
- `pu_result`, input, `PU2ROB_t[NUM_PU]`: PU result payload (`rob_entry`, `w_data`, `w_valid`, `vsaturate`, and `uop_pc` under `TB_SUPPORT`).
- `pu_result_ready`, output, `[NUM_PU]`: the collector can accept a result from that PU.
- `rob_wr_valid`, output, `[NUM_WR]`: ROB write strobe.
- `rob_wr_data`, output, `PU2ROB_t[NUM_WR]`: ROB write payload.
- `collector_idle`, output, 1: all FIFOs are empty.

## Operation

- Each PU port has one FIFO of `FIFO_DEPTH` entries, with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap modulo depth, and a count of `$clog2(FIFO_DEPTH)+1` bits.
- `pu_result_ready[i] = (count[i] != FIFO_DEPTH)`. It depends on registered state only.
  - There is no combinational path from any valid signal to any ready signal. The PUs derive `pop_rs` combinationally from ready, so this rule is mandatory.
- Enqueue happens on PU `i` when `pu_result_valid[i] & pu_result_ready[i]`, except in a flush cycle.
- Arbitration runs every cycle over the non-empty FIFOs. A 2-bit register `rr_ptr` (`$clog2(NUM_PU)` bits) selects the scan start.
  - The scan goes from `rr_ptr` upward, wrapping at `NUM_PU`.
  - The first `NUM_WR` non-empty FIFOs are granted. Write slot k receives the k-th grant, so grants pack into the low slots.
  - Each granted FIFO's head drives `rob_wr_data[k]`, and `rob_wr_valid[k]=1`. Unused slots have valid 0 and data 0.
  - Every granted FIFO dequeues at the end of the cycle. The ROB always accepts; there is no backpressure from the ROB.
  - If any grant occurs, `rr_ptr` becomes (last granted index + 1) mod `NUM_PU`. Otherwise it holds.
- At most one entry per PU is written per cycle. Within one PU, order is FIFO order.
- Enqueue and dequeue on the same FIFO in the same cycle leaves the count unchanged and advances both pointers.
- `collector_idle = (all counts == 0)`. Incoming valids are ignored for this output.
- Flush: when `trap_flush_rvv` = 1 in a cycle:
  - `rob_wr_valid` is forced to all 0.
  - There are no dequeues and no enqueues. An input handshake in that cycle is discarded, but ready still reflects pre-flush state, so the PU sees the handshake as complete.
  - At the clock edge, all counts and pointers clear and `rr_ptr` becomes 0.
- Reset (asynchronous, while `rst_n`=1):
  - Counts, pointers and `rr_ptr` are 0.
  - Every `pu_result_ready` is 1, every `rob_wr_valid` is 0, `rob_wr_data` is 0, and `collector_idle` is 1.
  - Reset asserted mid-operation drops all buffered results immediately. FIFO payload storage needs no reset.

## Timing

- Latency: a handshake at cycle N appears on `rob_wr_*` in cycle N+1 at the earliest. This holds whenever it wins arbitration. The ROB captures it at the end of N+1.
- The write outputs are combinational from FIFO heads and `rr_ptr` only. They do not depend on the `pu_*` inputs in the same cycle.
- Per-PU throughput is 1 result per cycle in steady state, since the count stays ≤1 when the FIFO is drained every cycle.
- A full FIFO deasserts ready even in a cycle in which it dequeues. Ready returns the cycle after the dequeue.
- Worst-case wait with all PUs busy is `ceil(NUM_PU/NUM_WR)` cycles. Starvation is impossible.

## Test plan

- Reset / idle: assert `rst_n`=1 mid-stream, with the FIFOs holding 3 entries. Required: all `rob_wr_valid`=0, all ready=1 and `collector_idle`=1 immediately. After release, no stale writes appear.
- Single PU latency: PU0 sends `rob_entry`=5 at cycle 10. Required: `rob_wr_valid[0]`=1 with `rob_entry`=5 in cycle 11, then idle again in cycle 12.
- Round-robin fairness: with `NUM_PU`=4 and `NUM_WR`=2, all four PUs hold valid continuously from `rr_ptr`=0. Required: grants alternate {0,1}, {2,3}, {0,1}, …, and each PU's `rob_entry` sequence is preserved.
- Backpressure: PU2 sends 3 results in back-to-back cycles while `NUM_WR` slots are saturated by PU0/1 (starting at `rr_ptr`=0). Required: `pu_result_ready[2]`=0 when count=2, no loss and no duplication, and in-order writes.
- Flush: with PU1 holding 2 entries, pulse `trap_flush_rvv` while PU3 handshakes `rob_entry`=7. Required: `rob_wr_valid`=0 in the flush cycle, entry 7 is never written, `collector_idle`=1 and `rr_ptr`=0 in the next cycle.
- Simultaneous enqueue/dequeue: a PU0 FIFO with count 1 receives a new result in the cycle its head is granted. Required: count stays 1, ready stays 1, and the next cycle writes the new entry.

Source files
------------

// File: rtl/rvv_backend_rob_result_collector.sv
// PU-to-ROB result collector: per-PU FIFOs, round-robin pick,
// up to NUM_WR ROB writes per cycle, flushed by trap_flush_rvv.
package rvv_backend_rob_rc_pkg;
  typedef struct packed {
`ifdef TB_SUPPORT
    logic [31:0]  uop_pc;
`endif
    logic [4:0]   rob_entry;
    logic [127:0] w_data;
    logic [15:0]  w_valid;
    logic         vsaturate;
  } PU2ROB_t;
  localparam int PU2ROB_W = $bits(PU2ROB_t);
endpackage

module rvv_backend_rob_result_collector
  import rvv_backend_rob_rc_pkg::*;
#(
  parameter int NUM_PU     = 4,
  parameter int NUM_WR     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trap_flush_rvv,
  input  logic [NUM_PU-1:0]          pu_result_valid,
  input  logic [NUM_PU*PU2ROB_W-1:0] pu_result,
  output logic [NUM_PU-1:0]          pu_result_ready,
  output logic [NUM_WR-1:0]          rob_wr_valid,
  output logic [NUM_WR*PU2ROB_W-1:0] rob_wr_data,
  output logic                       collector_idle
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  PU2ROB_t          mem_q  [NUM_PU][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q [NUM_PU];
  logic [PTR_W-1:0] wptr_d [NUM_PU];
  logic [PTR_W-1:0] rptr_q [NUM_PU];
  logic [PTR_W-1:0] rptr_d [NUM_PU];
  logic [CNT_W-1:0] cnt_q  [NUM_PU];
  logic [CNT_W-1:0] cnt_d  [NUM_PU];
  logic [RR_W-1:0]  rr_q, rr_d;

  logic [NUM_PU-1:0] nempty, gnt, enq, deq;
  logic [NUM_WR-1:0] slot_vld;
  logic [RR_W-1:0]   slot_src [NUM_WR];

  // Ready comes only from registered counts: PUs pop combinationally on it.
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      nempty[i]          = (cnt_q[i] != '0);
      pu_result_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
    end
  end

  assign collector_idle = ~|nempty;
  assign enq = pu_result_valid & pu_result_ready
             & {NUM_PU{~trap_flush_rvv}};
  assign deq = gnt & {NUM_PU{~trap_flush_rvv}};

  // Slot s takes the s-th non-empty FIFO scanning up from rr_q.
  always_comb begin
    logic [NUM_PU-1:0] avail;
    logic [RR_W-1:0]   idx;
    avail    = nempty;
    idx      = '0;
    gnt      = '0;
    slot_vld = '0;
    rr_d     = rr_q;
    for (int s = 0; s < NUM_WR; s++) slot_src[s] = '0;
    for (int s = 0; s < NUM_WR; s++) begin
      for (int k = 0; k < NUM_PU; k++) begin
        idx = RR_W'((int'(rr_q) + k) % NUM_PU);
        if (!slot_vld[s] && avail[idx]) begin
          slot_vld[s] = 1'b1;
          slot_src[s] = idx;
          avail[idx]  = 1'b0;
          gnt[idx]    = 1'b1;
          rr_d        = RR_W'((int'(idx) + 1) % NUM_PU);
        end
      end
    end
  end

  always_comb begin
    rob_wr_valid = slot_vld & {NUM_WR{~trap_flush_rvv}};
    rob_wr_data  = '0;
    for (int s = 0; s < NUM_WR; s++) begin
      if (rob_wr_valid[s])
        rob_wr_data[s*PU2ROB_W +: PU2ROB_W] =
          mem_q[slot_src[s]][rptr_q[slot_src[s]]];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      wptr_d[i] = wptr_q[i] + PTR_W'(enq[i]);
      rptr_d[i] = rptr_q[i] + PTR_W'(deq[i]);
      cnt_d[i]  = cnt_q[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_PU; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q <= '0;
    end else if (trap_flush_rvv) begin
      for (int i = 0; i < NUM_PU; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PU; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q <= rr_d;
    end
  end

  // Payload storage is qualified by the counts, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PU; i++) begin
      if (enq[i])
        mem_q[i][wptr_q[i]] <= pu_result[i*PU2ROB_W +: PU2ROB_W];
    end
  end

endmodule

// File: tb/tb_rvv_backend_rob_result_collector.sv
// Bench for rvv_backend_rob_result_collector: directed stimulus,
// per-PU expected queues drained by a negedge monitor.
module tb_rvv_backend_rob_result_collector;
  import rvv_backend_rob_rc_pkg::*;

  localparam int NPU = 4;
  localparam int NWR = 2;
  localparam int PW  = PU2ROB_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic [NPU-1:0]    vld   = '0;
  logic [NPU*PW-1:0] res   = '0;
  logic [NPU-1:0]    rdy;
  logic [NWR-1:0]    wv;
  logic [NWR*PW-1:0] wd;
  logic              idle;

  int checks = 0;
  int errors = 0;

  PU2ROB_t exp_q  [NPU][$];
  PU2ROB_t send_q [NPU][$];
  int      ord_q[$];
  bit      chk_order = 1'b0;
  bit      bp_seen [NPU];

  PU2ROB_t mon_got, mon_exp;
  int      mon_pu;

  rvv_backend_rob_result_collector #(
    .NUM_PU(NPU), .NUM_WR(NWR), .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_flush_rvv (flush),
    .pu_result_valid(vld),
    .pu_result      (res),
    .pu_result_ready(rdy),
    .rob_wr_valid   (wv),
    .rob_wr_data    (wd),
    .collector_idle (idle)
  );

  always #5 clk = ~clk;

  function automatic PU2ROB_t mk(int pu, int tag);
    PU2ROB_t r;
    r = '0;
    r.rob_entry         = 5'(tag);
    r.w_data[127:124]   = 4'(pu);
    r.w_data[7:0]       = 8'(tag);
    r.w_valid           = 16'hffff;
    r.vsaturate         = tag[0];
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic drive(int pu, int tag);
    vld[pu] = 1'b1;
    res[pu*PW +: PW] = mk(pu, tag);
  endtask

  task automatic send_exp(int pu, int tag);
    send_q[pu].push_back(mk(pu, tag));
    exp_q[pu].push_back(mk(pu, tag));
  endtask

  // PU-side driver: hold each queued result until it is accepted.
  task automatic stream(int budget);
    logic [NPU-1:0] hs;
    int n, pend;
    n = 0;
    while (n < budget) begin
      for (int i = 0; i < NPU; i++) begin
        vld[i] = (send_q[i].size() > 0);
        if (vld[i]) res[i*PW +: PW] = send_q[i][0];
      end
      @(negedge clk);
      for (int i = 0; i < NPU; i++) begin
        hs[i] = vld[i] & rdy[i];
        if (vld[i] && !rdy[i]) bp_seen[i] = 1'b1;
      end
      cyc();
      for (int i = 0; i < NPU; i++)
        if (hs[i]) void'(send_q[i].pop_front());
      pend = 0;
      for (int i = 0; i < NPU; i++) pend += send_q[i].size();
      n++;
      if (pend == 0 && idle) break;
    end
    vld = '0;
    chk("stream_done", (n < budget) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NWR; k++) begin
        if (wv[k]) begin
          mon_got = wd[k*PW +: PW];
          mon_pu  = int'(mon_got.w_data[127:124]);
          checks++;
          if (mon_pu >= NPU || exp_q[mon_pu].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write slot%0d: got pu %0d entry %0d, none expected",
                     k, mon_pu, mon_got.rob_entry);
          end else begin
            mon_exp = exp_q[mon_pu].pop_front();
            if (mon_got !== mon_exp) begin
              errors++;
              $display("FAIL wr_payload slot%0d pu%0d: got entry %0d data %0h expected entry %0d data %0h",
                       k, mon_pu, mon_got.rob_entry, mon_got.w_data,
                       mon_exp.rob_entry, mon_exp.w_data);
            end
          end
          if (chk_order) begin
            checks++;
            if (ord_q.size() == 0 || ord_q[0] != mon_pu) begin
              errors++;
              $display("FAIL rr_order slot%0d: got pu %0d expected pu %0d",
                       k, mon_pu, (ord_q.size() > 0) ? ord_q[0] : -1);
            end
            if (ord_q.size() > 0) void'(ord_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy, 4'hf);
    chk("rst_wr_valid", wv, 2'b00);
    chk("rst_idle", idle, 1);
    chk("rst_wdata_zero", (wd == '0) ? 1 : 0, 1);
    rst_n = 1'b0;
    cyc();

    // single PU latency
    exp_q[0].push_back(mk(0, 5));
    drive(0, 5);
    cyc();
    vld = '0;
    chk("lat_valid_n1", wv, 2'b01);
    chk("lat_busy_n1", idle, 0);
    cyc();
    chk("lat_valid_n2", wv, 2'b00);
    chk("lat_idle_n2", idle, 1);

    // round-robin fairness from rr_ptr = 0
    do_flush();
    for (int i = 0; i < NPU; i++)
      for (int j = 0; j < 4; j++) send_exp(i, 8*i + j);
    for (int r = 0; r < 8; r++) begin
      ord_q.push_back(2*(r % 2));
      ord_q.push_back(2*(r % 2) + 1);
    end
    chk_order = 1'b1;
    stream(60);
    chk_order = 1'b0;
    chk("rr_order_drained", ord_q.size(), 0);

    // backpressure on PU2 while PU0/PU1 compete
    do_flush();
    for (int i = 0; i < NPU; i++) bp_seen[i] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      send_exp(0, 1 + j);
      send_exp(1, 11 + j);
    end
    for (int j = 0; j < 3; j++) send_exp(2, 21 + j);
    stream(60);
    chk("bp_ready2_low", bp_seen[2], 1);

    // flush with PU1 holding two entries, PU3 handshaking entry 7
    do_flush();
    exp_q[2].push_back(mk(2, 17));
    drive(2, 17);
    cyc();
    vld = '0;
    cyc();
    cyc();
    exp_q[0].push_back(mk(0, 32));
    exp_q[3].push_back(mk(3, 64));
    drive(0, 32);
    drive(1, 48);
    drive(3, 64);
    cyc();
    vld = '0;
    drive(1, 49);
    cyc();
    vld = '0;
    flush = 1'b1;
    drive(3, 7);
    #1;
    chk("flush_wr_valid", wv, 2'b00);
    chk("flush_ready3_pre", rdy[3], 1);
    chk("flush_ready1_full", rdy[1], 0);
    cyc();
    flush = 1'b0;
    vld = '0;
    chk("post_flush_idle", idle, 1);
    chk("post_flush_rr", dut.rr_q, 0);
    chk("post_flush_wr_valid", wv, 2'b00);
    cyc();
    cyc();

    // simultaneous enqueue/dequeue on PU0
    exp_q[0].push_back(mk(0, 80));
    drive(0, 80);
    cyc();
    exp_q[0].push_back(mk(0, 81));
    drive(0, 81);
    chk("sim_ready_c1", rdy[0], 1);
    chk("sim_wv_c1", wv, 2'b01);
    chk("sim_cnt_c1", dut.cnt_q[0], 1);
    cyc();
    vld = '0;
    chk("sim_cnt_c2", dut.cnt_q[0], 1);
    chk("sim_ready_c2", rdy[0], 1);
    chk("sim_wv_c2", wv, 2'b01);
    cyc();
    chk("sim_idle_c3", idle, 1);

    // reset mid-stream with three buffered entries
    do_flush();
    drive(0, 96);
    drive(1, 97);
    drive(2, 98);
    cyc();
    vld = '0;
    chk("pre_rst_busy", idle, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_wr_valid", wv, 2'b00);
    chk("mid_rst_ready", rdy, 4'hf);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_wdata_zero", (wd == '0) ? 1 : 0, 1);
    cyc();
    rst_n = 1'b0;
    repeat (4) cyc();
    chk("post_rst_idle", idle, 1);

    for (int i = 0; i < NPU; i++)
      chk($sformatf("exp_drained_pu%0d", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
